// File: rtl/spwm_pkg.sv
// Shared constants and state encoding for the three-phase SPWM sequencer.
package spwm_pkg;

  localparam int unsigned LUT_SIZE = 407;
  localparam int unsigned DATA_W   = 12;
  localparam int unsigned ADDR_W   = 9;

  // Phase offsets into one sine period: 0, 1/3 and 2/3 of the table, rounded
  localparam int unsigned OFF_B = (LUT_SIZE + 1) / 3;
  localparam int unsigned OFF_C = (2 * LUT_SIZE + 1) / 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    RD_A = 3'd2,
    RD_B = 3'd3,
    RD_C = 3'd4,
    CAPT = 3'd5
  } state_t;

endpackage

// File: rtl/spwm_prescaler.sv
// Sample-rate prescaler: counts 0..div and flags the terminal count.
module spwm_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == div);
  assign tick   = enable && !clear && w_wrap;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_wrap ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spwm_phase_sequencer.sv
// Reads three 120-degree-spaced sine samples from an external table once per
// prescaler tick and presents them as a registered A/B/C set.
module spwm_phase_sequencer #(
  parameter int unsigned LUT_SIZE = spwm_pkg::LUT_SIZE,
  parameter int unsigned DATA_W   = spwm_pkg::DATA_W,
  parameter int unsigned ADDR_W   = spwm_pkg::ADDR_W,
  parameter int unsigned DIV_W    = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  div,
  output logic              lut_rd,
  output logic [ADDR_W-1:0] lut_addr,
  input  logic [DATA_W-1:0] lut_data,
  output logic [DATA_W-1:0] sample_a,
  output logic [DATA_W-1:0] sample_b,
  output logic [DATA_W-1:0] sample_c,
  output logic              sample_vld,
  output logic              busy,
  output logic              overrun
);

  import spwm_pkg::*;

  localparam int unsigned       SUM_W     = ADDR_W + 1;
  localparam logic [SUM_W-1:0]  LUT_SZ    = SUM_W'(LUT_SIZE);
  localparam logic [SUM_W-1:0]  OFFS_B    = SUM_W'((LUT_SIZE + 1) / 3);
  localparam logic [SUM_W-1:0]  OFFS_C    = SUM_W'((2 * LUT_SIZE + 1) / 3);
  localparam logic [ADDR_W-1:0] BASE_LAST = ADDR_W'(LUT_SIZE - 1);

  // Base + offset folded back into the table; sum is one bit wider than the address
  function automatic logic [ADDR_W-1:0] phase_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [SUM_W-1:0]  offs);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, base} + offs;
    if (sum >= LUT_SZ) begin
      sum = sum - LUT_SZ;
    end
    return sum[ADDR_W-1:0];
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  w_div_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] w_base_nxt;
  logic              r_pending;
  logic              w_pending_nxt;
  logic              r_overrun;
  logic              w_overrun_nxt;
  logic              r_lut_rd;
  logic              w_lut_rd_nxt;
  logic [ADDR_W-1:0] r_lut_addr;
  logic [ADDR_W-1:0] w_lut_addr_nxt;
  logic [DATA_W-1:0] r_sample_a;
  logic [DATA_W-1:0] r_sample_b;
  logic [DATA_W-1:0] r_sample_c;
  logic [DATA_W-1:0] w_sample_a_nxt;
  logic [DATA_W-1:0] w_sample_b_nxt;
  logic [DATA_W-1:0] w_sample_c_nxt;
  logic              r_sample_vld;
  logic              w_sample_vld_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              w_tick;
  logic              w_ready;
  logic              w_consume;
  logic              w_ps_clear;
  logic              w_ps_enable;

  assign w_ps_clear  = (r_state == IDLE);
  assign w_ps_enable = (r_state != IDLE);

  spwm_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .clear  (w_ps_clear),
    .enable (w_ps_enable),
    .div    (r_div),
    .tick   (w_tick)
  );

  assign w_ready = w_tick || r_pending;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_div_nxt        = r_div;
    w_base_nxt       = r_base;
    w_pending_nxt    = r_pending;
    w_overrun_nxt    = r_overrun;
    w_lut_rd_nxt     = 1'b0;
    w_lut_addr_nxt   = r_lut_addr;
    w_sample_a_nxt   = r_sample_a;
    w_sample_b_nxt   = r_sample_b;
    w_sample_c_nxt   = r_sample_c;
    w_sample_vld_nxt = 1'b0;
    w_consume        = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nxt   = WAIT;
          w_div_nxt     = div;
          w_overrun_nxt = 1'b0;
        end
      end
      WAIT: begin
        if (w_ready) begin
          w_state_nxt = RD_A;
          w_consume   = 1'b1;
        end
      end
      RD_A: w_state_nxt = RD_B;
      RD_B: begin
        w_state_nxt    = RD_C;
        w_sample_a_nxt = lut_data;
      end
      RD_C: begin
        w_state_nxt    = CAPT;
        w_sample_b_nxt = lut_data;
      end
      CAPT: begin
        w_sample_c_nxt   = lut_data;
        w_sample_vld_nxt = 1'b1;
        w_base_nxt       = (r_base == BASE_LAST) ? '0 : r_base + ADDR_W'(1);
        // Chain straight into the next read when a tick is already due so a
        // four-cycle tick period is sustained without a WAIT bubble
        if (!en) begin
          w_state_nxt = IDLE;
        end else if (w_ready) begin
          w_state_nxt = RD_A;
          w_consume   = 1'b1;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_state_nxt == IDLE) begin
      w_pending_nxt = 1'b0;
    end else if (w_consume) begin
      w_pending_nxt = w_tick && r_pending;
    end else if (w_tick) begin
      w_pending_nxt = 1'b1;
    end
    if (w_tick && r_pending && (r_state != WAIT) && (w_state_nxt != IDLE)) begin
      w_overrun_nxt = 1'b1;
    end

    unique case (w_state_nxt)
      RD_A: begin
        w_lut_rd_nxt   = 1'b1;
        w_lut_addr_nxt = phase_addr(w_base_nxt, '0);
      end
      RD_B: begin
        w_lut_rd_nxt   = 1'b1;
        w_lut_addr_nxt = phase_addr(w_base_nxt, OFFS_B);
      end
      RD_C: begin
        w_lut_rd_nxt   = 1'b1;
        w_lut_addr_nxt = phase_addr(w_base_nxt, OFFS_C);
      end
      default: ;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_div        <= '0;
      r_base       <= '0;
      r_pending    <= 1'b0;
      r_overrun    <= 1'b0;
      r_lut_rd     <= 1'b0;
      r_lut_addr   <= '0;
      r_sample_a   <= '0;
      r_sample_b   <= '0;
      r_sample_c   <= '0;
      r_sample_vld <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_div        <= w_div_nxt;
      r_base       <= w_base_nxt;
      r_pending    <= w_pending_nxt;
      r_overrun    <= w_overrun_nxt;
      r_lut_rd     <= w_lut_rd_nxt;
      r_lut_addr   <= w_lut_addr_nxt;
      r_sample_a   <= w_sample_a_nxt;
      r_sample_b   <= w_sample_b_nxt;
      r_sample_c   <= w_sample_c_nxt;
      r_sample_vld <= w_sample_vld_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign lut_rd     = r_lut_rd;
  assign lut_addr   = r_lut_addr;
  assign sample_a   = r_sample_a;
  assign sample_b   = r_sample_b;
  assign sample_c   = r_sample_c;
  assign sample_vld = r_sample_vld;
  assign busy       = r_busy;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_spwm_phase_sequencer.sv
// Bench for spwm_phase_sequencer: table-driven runs plus corner sequences,
// with an A/B/C scoreboard fed from a modulo-arithmetic reference.
module tb_spwm_phase_sequencer;

  localparam int unsigned LUT_SIZE = 407;
  localparam int unsigned DATA_W   = 12;
  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned DIV_W    = 16;

  logic              clk_in = 1'b0;
  logic              rst_n  = 1'b0;
  logic              en     = 1'b0;
  logic [DIV_W-1:0]  div    = '0;
  logic              lut_rd;
  logic [ADDR_W-1:0] lut_addr;
  logic [DATA_W-1:0] lut_data = '0;
  logic [DATA_W-1:0] sample_a;
  logic [DATA_W-1:0] sample_b;
  logic [DATA_W-1:0] sample_c;
  logic              sample_vld;
  logic              busy;
  logic              overrun;

  spwm_phase_sequencer #(
    .LUT_SIZE (LUT_SIZE),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DIV_W    (DIV_W)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .en         (en),
    .div        (div),
    .lut_rd     (lut_rd),
    .lut_addr   (lut_addr),
    .lut_data   (lut_data),
    .sample_a   (sample_a),
    .sample_b   (sample_b),
    .sample_c   (sample_c),
    .sample_vld (sample_vld),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk_in = ~clk_in;

  // External table: data equals address, one cycle after the read strobe
  always @(posedge clk_in) begin
    if (lut_rd) lut_data <= DATA_W'(lut_addr);
  end

  typedef struct {
    int a;
    int b;
    int c;
  } set_t;

  typedef struct {
    int div;
    int nsets;
    int period;
  } vec_t;

  set_t sb_q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   mdl_base = 0;
  int   vld_cnt  = 0;
  int   last_vld = -1;
  int   last_per = 0;
  bit   per_ok   = 1'b0;
  bit   sb_auto  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_addr(input int base, input int k);
    int offs;
    offs = (k == 0) ? 0 : ((k == 1) ? (LUT_SIZE + 1) / 3 : (2 * LUT_SIZE + 1) / 3);
    return (base + offs) % LUT_SIZE;
  endfunction

  task automatic push_sets(input int n);
    set_t s;
    for (int i = 0; i < n; i++) begin
      s.a = exp_addr(mdl_base, 0);
      s.b = exp_addr(mdl_base, 1);
      s.c = exp_addr(mdl_base, 2);
      sb_q.push_back(s);
      mdl_base = (mdl_base + 1) % LUT_SIZE;
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge and scoreboarded
  task automatic step();
    set_t s;
    @(posedge clk_in);
    #1;
    cyc++;
    if (sample_vld) begin
      vld_cnt++;
      per_ok = (last_vld >= 0);
      if (per_ok) last_per = cyc - last_vld;
      last_vld = cyc;
      if (sb_q.size() == 0 && sb_auto) push_sets(1);
      if (sb_q.size() == 0) begin
        check("unexpected_sample_vld", 1, 0);
      end else begin
        s = sb_q.pop_front();
        check("sample_a", int'(sample_a), s.a);
        check("sample_b", int'(sample_b), s.b);
        check("sample_c", int'(sample_c), s.c);
      end
    end
  endtask

  task automatic collect(input int n, input int per);
    int start;
    int budget;
    int prev;
    start  = vld_cnt;
    budget = n * (per + 6) + 30;
    while ((vld_cnt - start) < n && budget > 0) begin
      prev = vld_cnt;
      step();
      budget--;
      if (vld_cnt != prev && per_ok) check("vld_period", last_per, per);
    end
    if ((vld_cnt - start) < n) check("collect_timeout", vld_cnt - start, n);
  endtask

  task automatic finish_run();
    int budget;
    en = 1'b0;
    budget = 60;
    step();
    while (busy && budget > 0) begin
      step();
      budget--;
    end
    check("idle_busy", int'(busy), 0);
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  task automatic run_vec(input int d, input int n, input int per);
    div      = DIV_W'(d);
    last_vld = -1;
    push_sets(n + 1);
    en = 1'b1;
    collect(n, per);
    finish_run();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lut_rd"},     int'(lut_rd), 0);
    check({tag, "_lut_addr"},   int'(lut_addr), 0);
    check({tag, "_sample_a"},   int'(sample_a), 0);
    check({tag, "_sample_b"},   int'(sample_b), 0);
    check({tag, "_sample_c"},   int'(sample_c), 0);
    check({tag, "_sample_vld"}, int'(sample_vld), 0);
    check({tag, "_busy"},       int'(busy), 0);
    check({tag, "_overrun"},    int'(overrun), 0);
  endtask

  task automatic wait_rd(input string tag);
    int budget;
    budget = 14;
    while (!lut_rd && budget > 0) begin
      step();
      budget--;
    end
    check({tag, "_rd_seen"}, int'(lut_rd), 1);
  endtask

  initial begin
    vec_t vecs[5];
    int   b;
    int   nrd;
    int   v0;
    int   budget;

    vecs[0] = '{div: 3, nsets: 3,   period: 4};
    vecs[1] = '{div: 5, nsets: 2,   period: 6};
    vecs[2] = '{div: 4, nsets: 2,   period: 5};
    vecs[3] = '{div: 9, nsets: 2,   period: 10};
    vecs[4] = '{div: 3, nsets: 400, period: 4};

    rst_n = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // First run after reset starts at base 0; the long run wraps 406 -> 0
    foreach (vecs[i]) run_vec(vecs[i].div, vecs[i].nsets, vecs[i].period);

    // div=1 overruns quickly; flag survives en low, clears on restart
    sb_auto  = 1'b1;
    div      = DIV_W'(1);
    last_vld = -1;
    en       = 1'b1;
    for (int i = 0; i < 8 && !overrun; i++) step();
    check("overrun_set", int'(overrun), 1);
    finish_run();
    check("overrun_sticky", int'(overrun), 1);
    div      = DIV_W'(3);
    last_vld = -1;
    en       = 1'b1;
    step();
    check("overrun_cleared", int'(overrun), 0);
    check("restart_busy", int'(busy), 1);

    // en dropped during RD_A: the set still completes, then IDLE
    wait_rd("abort");
    b   = mdl_base;
    check("abort_addr_a", int'(lut_addr), exp_addr(b, 0));
    en  = 1'b0;
    nrd = 1;
    v0  = vld_cnt;
    budget = 12;
    while (busy && budget > 0) begin
      step();
      budget--;
      if (lut_rd) begin
        check("abort_addr", int'(lut_addr), exp_addr(b, nrd));
        nrd++;
      end
    end
    check("abort_reads", nrd, 3);
    check("abort_vld_pulses", vld_cnt - v0, 1);
    check("abort_idle", int'(busy), 0);
    sb_auto = 1'b0;

    // Reset while in RD_B, then a fresh run from base 0
    sb_auto = 1'b1;
    div     = DIV_W'(3);
    en      = 1'b1;
    wait_rd("rst");
    step();
    check("rst_in_rd_b", int'(lut_rd), 1);
    rst_n = 1'b0;
    en    = 1'b0;
    step();
    check_all_zero("midrst");
    rst_n    = 1'b1;
    sb_auto  = 1'b0;
    mdl_base = 0;
    sb_q.delete();
    step();
    run_vec(3, 1, 4);

    // div change is ignored until the next IDLE exit
    div      = DIV_W'(3);
    last_vld = -1;
    push_sets(5);
    en = 1'b1;
    collect(2, 4);
    div = DIV_W'(9);
    collect(2, 4);
    finish_run();
    run_vec(9, 2, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
